router_fifo: RTL and testbench

Per-destination packet buffer for the 1x3 router, directly downstream of the register stage. It stores the byte stream that stage drives, with a header-marker bit per entry taken from `lfd_state`. It returns the bytes to the destination client in order and tracks packet boundaries using the length field in the header byte. Three instances sit in the router, one per output port; write enables come from the synchronizer, and the read side is driven by the client.

---
 rtl/router_fifo_if.sv | 24 ++
 rtl/router_fifo.sv | 79 +++++++
 tb/tb_router_fifo.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_fifo_if.sv
// Byte-stream port bundle between the router write/read side and one router_fifo.
// master drives the write and read enables; slave is the FIFO itself.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_done;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, full, empty, pkt_done
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, full, empty, pkt_done
  );
endinterface

// File: rtl/router_fifo.sv
// Per-destination packet buffer: DEPTH x (WIDTH+1) with header flag, 1-cycle registered read.
// Writes drop while full, reads ignored while empty; flags come from registered pointers only.
module router_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          soft_reset,
  router_fifo_if.slave  bus
);

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic [6:0]       r_byte_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_done_pend;
  logic             r_pkt_done;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH:0]   w_rd_entry;
  logic [6:0]       w_hdr_cnt;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                      (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign w_wr_acc   = bus.write_enb && !w_full;
  assign w_rd_acc   = bus.read_enb && !w_empty;
  assign w_rd_entry = r_mem[r_rd_ptr[ADDR_W-1:0]];
  // Header length field plus one for the trailing parity byte.
  assign w_hdr_cnt  = 7'(w_rd_entry[WIDTH-1:2]) + 7'd1;

  always_ff @(posedge clock) begin
    if (!reset && !soft_reset && w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_byte_cnt  <= '0;
      r_data_out  <= '0;
      r_done_pend <= 1'b0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_pkt_done  <= r_done_pend;
      r_done_pend <= 1'b0;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= w_rd_entry[WIDTH-1:0];
        if (w_rd_entry[WIDTH]) begin
          r_byte_cnt <= w_hdr_cnt;
        end else if (r_byte_cnt != 7'd0) begin
          r_byte_cnt <= r_byte_cnt - 7'd1;
          // Final byte read now; the done pulse follows one edge later.
          r_done_pend <= (r_byte_cnt == 7'd1);
        end
      end else if (r_byte_cnt == 7'd0) begin
        r_data_out <= '0;
      end
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.pkt_done = r_pkt_done;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: packet vectors from a table plus scoreboarded sequences.
module tb_router_fifo;

  logic clock = 1'b0;
  logic reset;
  logic soft_reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] sb[$];

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we;
    logic       lfd;
    logic [7:0] din;
    logic       re;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic lfd, input logic [7:0] din,
                              input logic re, input logic [7:0] dout,
                              input logic empty, input logic done);
    vec_t v;
    v.we = we; v.lfd = lfd; v.din = din; v.re = re;
    v.dout = dout; v.full = 1'b0; v.empty = empty; v.done = done;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got 0x%0h expected <scoreboard empty>", name, bus.data_out);
    end else begin
      check(name, 32'(bus.data_out), 32'(sb.pop_front()));
    end
  endtask

  task automatic drive(input logic we, input logic lfd, input logic [7:0] d, input logic re);
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    bus.read_enb  = re;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    soft_reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Packet table: header 0x0C len 3 with a mid-packet idle, then a zero-length header.
    tbl.push_back(mk(1, 1, 8'h0C, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'hA1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'hA2, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'hA3, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'h0E, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h0C, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'hA1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hA2, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hA3, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h0E, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 1, 8'h03, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 8'h03, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h03, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h03, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0));

    // Reset values
    do_reset();
    check("rst_dout", 32'(bus.data_out), 32'h00);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_done", 32'(bus.pkt_done), 32'd0);
    check("rst_cnt", 32'(dut.r_byte_cnt), 32'd0);

    // Fill to full, drop a 17th write, drain in order
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(i + 1), 1'b0);
      sb.push_back(8'(i + 1));
      step();
      check("fill_full", 32'(bus.full), (i == 15) ? 32'd1 : 32'd0);
      check("fill_empty", 32'(bus.empty), 32'd0);
    end
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    step();
    check("drop_full", 32'(bus.full), 32'd1);
    check("drop_wrptr", 32'(dut.r_wr_ptr), 32'd16);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      step();
      sb_check("drain_data");
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_full", 32'(bus.full), 32'd0);

    // Table-driven packet vectors
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].lfd, tbl[i].din, tbl[i].re);
      step();
      check($sformatf("tbl%0d_dout", i), 32'(bus.data_out), 32'(tbl[i].dout));
      check($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].full));
      check($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].empty));
      check($sformatf("tbl%0d_done", i), 32'(bus.pkt_done), 32'(tbl[i].done));
    end

    // Streaming with occupancy 1 across pointer wrap
    do_reset();
    drive(1'b1, 1'b0, 8'h40, 1'b0);
    sb.push_back(8'h40);
    step();
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 8'(8'h41 + i), 1'b1);
      sb.push_back(8'(8'h41 + i));
      step();
      sb_check("stream_data");
      check("stream_empty", 32'(bus.empty), 32'd0);
      check("stream_full", 32'(bus.full), 32'd0);
    end
    check("stream_wrptr", 32'(dut.r_wr_ptr), 32'd9);
    check("stream_rdptr", 32'(dut.r_rd_ptr), 32'd8);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    sb_check("stream_last");
    check("stream_end_empty", 32'(bus.empty), 32'd1);

    // Mid-packet soft flush
    do_reset();
    drive(1'b1, 1'b1, 8'h10, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'(8'hB1 + i), 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check("flush_rd0", 32'(bus.data_out), 32'h10);
    step();
    check("flush_rd1", 32'(bus.data_out), 32'hB1);
    check("flush_cnt_pre", 32'(dut.r_byte_cnt), 32'd4);
    soft_reset = 1'b1;
    drive(1'b1, 1'b0, 8'hEE, 1'b1);
    step();
    soft_reset = 1'b0;
    check("flush_empty", 32'(bus.empty), 32'd1);
    check("flush_dout", 32'(bus.data_out), 32'h00);
    check("flush_cnt", 32'(dut.r_byte_cnt), 32'd0);
    check("flush_wrptr", 32'(dut.r_wr_ptr), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check("flush_nowrite", 32'(bus.empty), 32'd1);

    // Read on empty holds output; simultaneous read/write on empty stores only
    drive(1'b1, 1'b1, 8'h08, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check("hdr08_dout", 32'(bus.data_out), 32'h08);
    check("hdr08_cnt", 32'(dut.r_byte_cnt), 32'd3);
    step();
    check("rd_empty_dout", 32'(bus.data_out), 32'h08);
    check("rd_empty_rdptr", 32'(dut.r_rd_ptr), 32'd1);
    drive(1'b1, 1'b0, 8'h55, 1'b1);
    step();
    check("rw_empty_dout", 32'(bus.data_out), 32'h08);
    check("rw_empty_empty", 32'(bus.empty), 32'd0);
    check("rw_empty_rdptr", 32'(dut.r_rd_ptr), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check("rw_empty_later", 32'(bus.data_out), 32'h55);

    // Simultaneous read/write while full: read wins, write dropped
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
      sb.push_back(8'(8'h60 + i));
      step();
    end
    drive(1'b1, 1'b0, 8'hFF, 1'b1);
    step();
    sb_check("rw_full_data");
    check("rw_full_full", 32'(bus.full), 32'd0);
    check("rw_full_wrptr", 32'(dut.r_wr_ptr), 32'd16);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      step();
      sb_check("rw_full_drain");
    end
    check("rw_full_end_empty", 32'(bus.empty), 32'd1);

    // Zero-length packet then hard reset mid-packet
    do_reset();
    drive(1'b1, 1'b1, 8'h03, 1'b0); step();
    drive(1'b1, 1'b0, 8'h03, 1'b0); step();
    drive(1'b1, 1'b1, 8'h14, 1'b0); step();
    drive(1'b1, 1'b0, 8'h01, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    check("z_hdr", 32'(bus.data_out), 32'h03);
    step();
    check("z_par_done", 32'(bus.pkt_done), 32'd0);
    step();
    check("z_done", 32'(bus.pkt_done), 32'd1);
    check("z_next_hdr", 32'(bus.data_out), 32'h14);
    check("z_next_cnt", 32'(dut.r_byte_cnt), 32'd6);
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h77, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("hrst_dout", 32'(bus.data_out), 32'h00);
    check("hrst_done", 32'(bus.pkt_done), 32'd0);
    check("hrst_empty", 32'(bus.empty), 32'd1);
    check("hrst_full", 32'(bus.full), 32'd0);
    check("hrst_cnt", 32'(dut.r_byte_cnt), 32'd0);
    check("hrst_rdptr", 32'(dut.r_rd_ptr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
